// File: rtl/countdown_ctrl.sv
// Countdown-timer controller: BCD MM:SS down-counter with run/pause control,
// a one-cycle expiry pulse and a tick-timed alarm level.
module countdown_ctrl #(
    parameter int unsigned ALARM_SECS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] time_o,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        load_err
);

    localparam int unsigned TW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   time_q, time_d;
    logic [CW-1:0]   alarm_cnt_q, alarm_cnt_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            alarm_q, alarm_d;
    logic            load_err_q, load_err_d;
    logic            cmd_acc;
    logic [TW-1:0]   time_dec;

    // Subtract one second from a BCD MM:SS value, borrowing digit by digit.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    function automatic logic bcd_valid(input logic [TW-1:0] t);
        return (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
               (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
    endfunction

    assign time_dec = bcd_dec(time_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            time_q      <= '0;
            alarm_cnt_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= running_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
            load_err_q  <= load_err_d;
        end
    end

    // Only the highest-priority asserted command is evaluated; an accepted
    // command swallows a coincident tick.
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;
        alarm_d     = alarm_q;
        load_err_d  = 1'b0;
        cmd_acc     = 1'b0;

        if (clear) begin
            cmd_acc     = 1'b1;
            state_d     = IDLE;
            time_d      = '0;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (load) begin
            if (state_q != RUN && bcd_valid(load_val)) begin
                cmd_acc     = 1'b1;
                state_d     = IDLE;
                time_d      = load_val;
                alarm_d     = 1'b0;
                alarm_cnt_d = '0;
            end else begin
                load_err_d  = 1'b1;
            end
        end else if (start) begin
            if ((state_q == IDLE || state_q == PAUSE) && time_q != '0) begin
                cmd_acc = 1'b1;
                state_d = RUN;
            end
        end else if (stop) begin
            if (state_q == RUN) begin
                cmd_acc = 1'b1;
                state_d = PAUSE;
            end
        end

        if (tick && !cmd_acc) begin
            case (state_q)
                RUN: begin
                    time_d = time_dec;
                    if (time_dec == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        alarm_d     = 1'b1;
                        alarm_cnt_d = CW'(ALARM_SECS);
                    end
                end
                DONE: begin
                    if (alarm_cnt_q != '0) begin
                        alarm_cnt_d = alarm_cnt_q - CW'(1);
                        if (alarm_cnt_q == CW'(1)) begin
                            alarm_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        running_d = (state_d == RUN);
    end

    assign time_o   = time_q;
    assign running  = running_q;
    assign done     = done_q;
    assign alarm    = alarm_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: countdown, borrow chain, load checks,
// pause/resume, alarm timing, reset and command priority.
module tb_countdown_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, start, stop, clear, load;
    logic [15:0] load_val;
    logic [15:0] time_o;
    logic        running, done, alarm, load_err;

    int checks = 0;
    int errors = 0;

    countdown_ctrl #(.ALARM_SECS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .time_o   (time_o),
        .running  (running),
        .done     (done),
        .alarm    (alarm),
        .load_err (load_err)
    );

    always #10 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tick = 0; start = 0; stop = 0; clear = 0; load = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1; load_val = v; step(); load = 0;
    endtask

    task automatic do_start();
        start = 1; step(); start = 0;
    endtask

    task automatic do_tick();
        tick = 1; step(); tick = 0;
    endtask

    task automatic do_clear();
        clear = 1; step(); clear = 0;
    endtask

    function automatic logic [15:0] secs_to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic test_reset();
        rst = 1; idle_inputs(); load_val = 16'h0000;
        step(); step();
        checks++;
        if (time_o !== 16'h0000 || running !== 1'b0 || done !== 1'b0 ||
            alarm !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: time=%h run=%b done=%b alarm=%b lerr=%b, expected 0000/0/0/0/0",
                     time_o, running, done, alarm, load_err);
        end
        rst = 0;
        step();
    endtask

    task automatic test_full_countdown();
        logic [15:0] exp_t;
        do_load(16'h0105);
        checks++;
        if (time_o !== 16'h0105 || running !== 1'b0) begin
            errors++;
            $display("FAIL cd_load: time=%h run=%b, expected 0105/0", time_o, running);
        end
        do_start();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL cd_start: running=%b, expected 1", running);
        end
        for (int k = 1; k <= 65; k++) begin
            do_tick();
            exp_t = secs_to_bcd(65 - k);
            checks++;
            if (time_o !== exp_t) begin
                errors++;
                $display("FAIL cd_time tick %0d: got %h expected %h", k, time_o, exp_t);
            end
            checks++;
            if (k < 65 && (done !== 1'b0 || running !== 1'b1)) begin
                errors++;
                $display("FAIL cd_flags tick %0d: done=%b run=%b, expected 0/1", k, done, running);
            end else if (k == 65 && (done !== 1'b1 || running !== 1'b0 || alarm !== 1'b1)) begin
                errors++;
                $display("FAIL cd_expire: done=%b run=%b alarm=%b, expected 1/0/1", done, running, alarm);
            end
            step();
        end
        checks++;
        if (done !== 1'b0 || alarm !== 1'b1) begin
            errors++;
            $display("FAIL cd_done_pulse: done=%b alarm=%b, expected 0/1", done, alarm);
        end
    endtask

    // Continues from the DONE state left by test_full_countdown.
    task automatic test_alarm();
        logic exp_alarm [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            do_tick();
            checks++;
            if (alarm !== exp_alarm[k]) begin
                errors++;
                $display("FAIL alarm tick %0d: got %b expected %b", k + 1, alarm, exp_alarm[k]);
            end
            step();
        end
        do_start();
        do_tick();
        checks++;
        if (running !== 1'b0 || alarm !== 1'b0 || time_o !== 16'h0000) begin
            errors++;
            $display("FAIL alarm_done_hold: run=%b alarm=%b time=%h, expected 0/0/0000",
                     running, alarm, time_o);
        end
    endtask

    task automatic test_borrow();
        do_clear();
        do_load(16'h1000);
        do_start();
        do_tick();
        checks++;
        if (time_o !== 16'h0959) begin
            errors++;
            $display("FAIL borrow1: got %h expected 0959", time_o);
        end
        step();
        do_tick();
        checks++;
        if (time_o !== 16'h0958) begin
            errors++;
            $display("FAIL borrow2: got %h expected 0958", time_o);
        end
    endtask

    task automatic test_load_err();
        logic [15:0] bad [3] = '{16'h0160, 16'h6000, 16'h010A};
        do_clear();
        do_load(16'h0130);
        for (int k = 0; k < 3; k++) begin
            do_load(bad[k]);
            checks++;
            if (load_err !== 1'b1 || time_o !== 16'h0130) begin
                errors++;
                $display("FAIL load_bad %h: lerr=%b time=%h, expected 1/0130", bad[k], load_err, time_o);
            end
            step();
            checks++;
            if (load_err !== 1'b0) begin
                errors++;
                $display("FAIL load_err_pulse: got %b expected 0", load_err);
            end
        end
        do_start();
        load = 1; load_val = 16'h0200; tick = 1;
        step();
        load = 0; tick = 0;
        checks++;
        if (load_err !== 1'b1 || time_o !== 16'h0129 || running !== 1'b1) begin
            errors++;
            $display("FAIL load_in_run: lerr=%b time=%h run=%b, expected 1/0129/1",
                     load_err, time_o, running);
        end
    endtask

    task automatic test_stop_tick();
        do_clear();
        do_load(16'h0031);
        do_start();
        do_tick();
        stop = 1; tick = 1;
        step();
        stop = 0; tick = 0;
        checks++;
        if (running !== 1'b0 || time_o !== 16'h0030) begin
            errors++;
            $display("FAIL stop_tick: run=%b time=%h, expected 0/0030", running, time_o);
        end
        for (int k = 0; k < 5; k++) begin
            do_tick();
        end
        checks++;
        if (time_o !== 16'h0030) begin
            errors++;
            $display("FAIL pause_ticks: got %h expected 0030", time_o);
        end
        do_start();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL resume: running=%b expected 1", running);
        end
        do_tick();
        checks++;
        if (time_o !== 16'h0029) begin
            errors++;
            $display("FAIL resume_tick: got %h expected 0029", time_o);
        end
    endtask

    task automatic test_clear_alarm();
        do_clear();
        do_load(16'h0002);
        do_start();
        do_tick();
        do_tick();
        checks++;
        if (done !== 1'b1 || alarm !== 1'b1 || time_o !== 16'h0000) begin
            errors++;
            $display("FAIL short_expire: done=%b alarm=%b time=%h, expected 1/1/0000", done, alarm, time_o);
        end
        do_tick();
        do_clear();
        checks++;
        if (alarm !== 1'b0 || time_o !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_alarm: alarm=%b time=%h run=%b done=%b, expected 0/0000/0/0",
                     alarm, time_o, running, done);
        end
    endtask

    task automatic test_start_zero();
        do_clear();
        do_start();
        checks++;
        if (running !== 1'b0 || time_o !== 16'h0000) begin
            errors++;
            $display("FAIL start_zero: run=%b time=%h, expected 0/0000", running, time_o);
        end
    endtask

    task automatic test_start_tick();
        do_load(16'h0003);
        start = 1; tick = 1;
        step();
        start = 0; tick = 0;
        checks++;
        if (running !== 1'b1 || time_o !== 16'h0003) begin
            errors++;
            $display("FAIL start_tick: run=%b time=%h, expected 1/0003", running, time_o);
        end
        do_tick();
        checks++;
        if (time_o !== 16'h0002) begin
            errors++;
            $display("FAIL start_tick_next: got %h expected 0002", time_o);
        end
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        do_load(16'h0011);
        do_start();
        do_tick();
        checks++;
        if (time_o !== 16'h0010 || running !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: time=%h run=%b, expected 0010/1", time_o, running);
        end
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (time_o !== 16'h0000 || running !== 1'b0 || done !== 1'b0 ||
            alarm !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: time=%h run=%b done=%b alarm=%b lerr=%b, expected 0000/0/0/0/0",
                     time_o, running, done, alarm, load_err);
        end
    endtask

    task automatic test_priority();
        do_load(16'h0020);
        clear = 1; load = 1; load_val = 16'h0045; start = 1;
        step();
        idle_inputs();
        checks++;
        if (time_o !== 16'h0000 || running !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL prio_clear: time=%h run=%b lerr=%b, expected 0000/0/0", time_o, running, load_err);
        end
        load = 1; load_val = 16'h0045; start = 1;
        step();
        idle_inputs();
        checks++;
        if (time_o !== 16'h0045 || running !== 1'b0) begin
            errors++;
            $display("FAIL prio_load: time=%h run=%b, expected 0045/0", time_o, running);
        end
    endtask

    initial begin
        test_reset();
        test_full_countdown();
        test_alarm();
        test_borrow();
        test_load_err();
        test_stop_tick();
        test_clear_alarm();
        test_start_zero();
        test_start_tick();
        test_reset_mid_run();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Countdown-timer controller: sequences a BCD MM:SS down-counter, advanced by the one-cycle 1 Hz tick from the seconds clock divider.
- Accepts start/stop/clear/load commands and tracks run state.
- Signals expiry with a one-cycle done pulse and a timed alarm level.
- Sits between the seconds tick generator and the display/buzzer logic.

Parameters:
- ALARM_SECS, 3: number of ticks the alarm output stays high after expiry (1..15).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clock-wide 1 Hz pulse from the seconds divider
- start  in  1  command pulse: begin/resume counting
- stop  in  1  command pulse: pause counting
- clear  in  1  command pulse: zero time, return to IDLE
- load  in  1  command pulse: load load_val
- load_val  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
- time_o  out  16  current BCD time, same packing as load_val
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse when the count reaches 00:00
- alarm  out  1  high for ALARM_SECS ticks after expiry
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are registered. A command sampled at edge N takes effect on the outputs after edge N.
- Reset: state=IDLE, time_o=16'h0000, running=0, done=0, alarm=0, load_err=0. Reset mid-run aborts immediately.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority when several are high in one cycle: clear > load > start > stop. Lower-priority commands in the same cycle are ignored.
- clear: from any state -> IDLE, time_o=0000, alarm=0.
- load:
  - Valid digits are: sec_ones<=9, sec_tens<=5, min_ones<=9, min_tens<=5.
  - Valid load in IDLE, PAUSE or DONE: time_o<=load_val, state->IDLE, alarm=0.
  - Invalid digit, or any load while in RUN: load_err pulses for 1 cycle; time_o and state are unchanged.
- start:
  - In IDLE or PAUSE with time_o!=0000: -> RUN.
  - With time_o==0000: no effect.
  - Ignored in RUN and DONE.
- stop: in RUN -> PAUSE. Ignored elsewhere.
- RUN with tick=1 and no command accepted that cycle: decrement time_o by one second using BCD borrow.
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_ones 0 -> 9 with borrow.
  - min_tens decrements.
- Decrement result 0000:
  - Same edge: state->DONE, running=0, done=1 for exactly one cycle, alarm=1, alarm tick counter loaded with ALARM_SECS.
- Simultaneous events:
  - Any accepted command in the same cycle as tick suppresses that tick's decrement.
  - start+tick in IDLE: enters RUN; the first decrement happens on the next tick.
  - stop+tick in RUN: -> PAUSE with no decrement.
- DONE:
  - Each tick decrements the alarm counter. alarm drops on the edge where the counter reaches 0, i.e. alarm is high for exactly ALARM_SECS tick edges.
  - State stays DONE until clear or a valid load; leaving DONE forces alarm=0 immediately.
- tick is ignored in IDLE and PAUSE.
- No wrap below 00:00 is possible, since RUN is never entered with time 0.
- Maximum time is 59:59.

Test Plan:
- rst, load 16'h0105, start, 65 ticks -> time_o walks 01:05 -> 01:00 -> 00:59 -> ... -> 00:00; done high exactly 1 cycle on the 65th tick; running drops the same cycle; state DONE.
- load 16'h1000, start, 1 tick -> time_o=16'h0959 (full borrow chain); a further tick -> 16'h0958.
- load 16'h0160 (sec_tens=6) -> load_err 1-cycle pulse, time_o unchanged. Load during RUN -> load_err, count continues.
- In RUN at 00:30, assert stop in the same cycle as tick -> PAUSE, time_o stays 00:30. 5 ticks -> no change. start -> RUN; next tick -> 00:29.
- Expiry with ALARM_SECS=3 -> alarm high over exactly 3 ticks, then low; state stays DONE. A clear during alarm -> alarm=0 next cycle, time_o=0000, IDLE.
- start with time_o=0000 -> stays IDLE, running=0.
- rst asserted mid-RUN at 00:10 -> next cycle all outputs at reset values.
- clear+load+start asserted together -> clear wins.
